// File: rtl/counter_seq.sv
// counter_seq: command sequencer driving an up/down counter's load/enable pins.
// Runs one count period per job, optionally auto-reloading, and counts completed periods.
module counter_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic             cmd_dir,
  input  logic             cmd_reload,
  input  logic             abort,
  input  logic             cnt_zero,
  input  logic             cnt_max,
  output logic             load_n,
  output logic [WIDTH-1:0] data_load,
  output logic             ce,
  output logic             up_down,
  output logic             busy,
  output logic             done,
  output logic [7:0]       periods
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;
  logic [7:0]       periods_q, periods_d;
  logic             term;

  assign term      = dir_q ? cnt_max : cnt_zero;
  assign data_load = start_q;
  assign up_down   = dir_q;
  assign periods   = periods_q;

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    dir_d     = dir_q;
    reload_d  = reload_q;
    periods_d = periods_q;
    cmd_ready = 1'b0;
    load_n    = 1'b1;
    ce        = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          start_d   = cmd_start;
          dir_d     = cmd_dir;
          reload_d  = cmd_reload;
          periods_d = 8'd0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        load_n  = abort;
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // abort wins over the terminal flag
        ce = ~term & ~abort;
        if (abort)
          state_d = S_IDLE;
        else if (term)
          state_d = S_DONE;
      end
      S_DONE: begin
        done = ~abort;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (periods_q != 8'hff)
            periods_d = periods_q + 8'd1;
          state_d = reload_q ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      start_q   <= '0;
      dir_q     <= 1'b0;
      reload_q  <= 1'b0;
      periods_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      dir_q     <= dir_d;
      reload_q  <= reload_d;
      periods_q <= periods_d;
    end
  end

endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: directed bench with a done-pulse scoreboard.
// A behavioural 4-bit up/down counter closes the loop around the sequencer.
module tb_counter_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_start;
  logic       cmd_dir;
  logic       cmd_reload;
  logic       abort;
  logic       cnt_zero;
  logic       cnt_max;
  logic       load_n;
  logic [3:0] data_load;
  logic       ce;
  logic       up_down;
  logic       busy;
  logic       done;
  logic [7:0] periods;

  counter_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_dir(cmd_dir),
    .cmd_reload(cmd_reload), .abort(abort),
    .cnt_zero(cnt_zero), .cnt_max(cnt_max),
    .load_n(load_n), .data_load(data_load),
    .ce(ce), .up_down(up_down), .busy(busy),
    .done(done), .periods(periods)
  );

  always #5 clk = ~clk;

  logic [3:0] cnt = 4'd0;
  always @(posedge clk) begin
    if (!load_n) cnt <= data_load;
    else if (ce) cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign cnt_zero = (cnt == 4'd0);
  assign cnt_max  = (cnt == 4'd15);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int per;
    int cnt;
    int n;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!load_n) ce_cnt = 0;
    else if (ce) ce_cnt++;
    chk("load_ce_excl", int'(!load_n && ce), 0);
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_periods", periods, e.per);
        chk("done_cnt", cnt, e.cnt);
        chk("done_ce_cycles", ce_cnt, e.n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] s, input logic d, input logic r,
                        output int a);
    cmd_valid  = 1'b1;
    cmd_start  = s;
    cmd_dir    = d;
    cmd_reload = r;
    a = cyc;
    chk("accept_ready", cmd_ready, 1);
    tick();
    cmd_valid  = 1'b0;
    cmd_start  = 4'hx;
    cmd_dir    = 1'bx;
    cmd_reload = 1'bx;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"}, cmd_ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ce"}, ce, 0);
    chk({nm, "_load_n"}, load_n, 1);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    int a, b;
    logic [3:0] st [2];
    logic       dr [2];
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_start  = 4'd0;
    cmd_dir    = 1'b0;
    cmd_reload = 1'b0;
    abort      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    chk("rst_periods", periods, 0);
    chk("rst_data_load", data_load, 0);
    chk("rst_up_down", up_down, 0);
    rst_n = 1'b1;
    tick();

    // single down count from 5
    accept(4'd5, 1'b0, 1'b0, a);
    q.push_back('{a + 8, 0, 0, 5});
    chk("down_load_n_c1", load_n, 0);
    chk("down_ce_c1", ce, 0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk($sformatf("down_ce_c%0d", k), ce, int'(k <= 6));
    end
    chk("down_cnt_c7", cnt, 0);
    tick();
    chk("down_ready_c8", cmd_ready, 0);
    tick();
    chk_idle("down_c9");
    chk("down_periods", periods, 1);

    // immediate terminal: down from 0, up from 15
    st[0] = 4'd0;  dr[0] = 1'b0;
    st[1] = 4'd15; dr[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      accept(st[i], dr[i], 1'b0, a);
      q.push_back('{a + 3, 0, int'(st[i]), 0});
      tick();
      chk($sformatf("imm%0d_ce_c2", i), ce, 0);
      repeat (2) tick();
      chk_idle($sformatf("imm%0d_c4", i));
      chk($sformatf("imm%0d_periods", i), periods, 1);
    end

    // abort in C4 of a down count from 9
    accept(4'd9, 1'b0, 1'b0, a);
    repeat (3) tick();
    chk("abort_cnt_c4", cnt, 7);
    abort = 1'b1;
    #1;
    chk("abort_ce_c4", ce, 0);
    chk("abort_done_c4", done, 0);
    tick();
    abort = 1'b0;
    chk_idle("abort_c5");
    chk("abort_periods", periods, 0);
    chk("abort_cnt_hold", cnt, 7);
    tick();
    chk("abort_cnt_hold2", cnt, 7);

    // second command held while busy
    cmd_valid  = 1'b1;
    cmd_start  = 4'd3;
    cmd_dir    = 1'b0;
    cmd_reload = 1'b0;
    a = cyc;
    chk("hs_accept_ready", cmd_ready, 1);
    tick();
    q.push_back('{a + 6, 0, 0, 3});
    cmd_start = 4'd2;
    cmd_dir   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("hs_ready_c%0d", k), cmd_ready, 0);
      chk($sformatf("hs_busy_c%0d", k), busy, 1);
      tick();
    end
    chk("hs_ready_c7", cmd_ready, 1);
    chk("hs_periods_c7", periods, 1);
    b = cyc;
    q.push_back('{b + 16, 0, 15, 13});
    tick();
    cmd_valid = 1'b0;
    chk("hs_periods_clear", periods, 0);
    chk("hs_load_n", load_n, 0);
    chk("hs_up_down", up_down, 1);
    chk("hs_data_load", data_load, 2);
    repeat (17) tick();
    chk_idle("hs_end");
    chk("hs_periods_end", periods, 1);

    // up from 13 with reload for 300 periods, then reset mid-RUN
    accept(4'd13, 1'b1, 1'b1, a);
    for (int k = 1; k <= 300; k++)
      q.push_back('{a + 5 * k, (k - 1 > 255) ? 255 : k - 1, 15, 2});
    repeat (1502) tick();
    chk("rl_periods_sat", periods, 255);
    chk("rl_busy", busy, 1);
    chk("rl_cnt", cnt, 14);
    chk("rl_ce_run", ce, 1);
    chk("rl_pending", q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk_idle("rstrun");
    chk("rstrun_periods", periods, 0);
    chk("rstrun_data_load", data_load, 0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk_idle("rstrun_after");

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
